// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller state encoding and round-robin approach selection
// for the traffic phase controller.
package traffic_pkg;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam int MAX_APPR = 32;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  // The current approach is never re-selected, so a held side sensor falls back to main first.
  function automatic int unsigned next_pending(input logic [MAX_APPR-1:0] pend,
                                               input int unsigned n,
                                               input int unsigned act);
    int unsigned idx;
    int unsigned sel;
    logic        found;
    sel   = 0;
    found = 1'b0;
    for (int unsigned i = 1; i < MAX_APPR; i++) begin
      if (i < n) begin
        idx = act + i;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!found && (idx != 0) && pend[idx[4:0]]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a single-cycle timing tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// Sensor-actuated N-approach traffic controller: main road rests green, side roads are
// served round-robin with min/max green, fixed yellow and all-red, and main-road pre-empt.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int N_APPR    = 2,
  parameter int TICK_DIV  = 1,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_APPR-1:0]         sensor,
  input  logic                      preempt,
  output logic [3*N_APPR-1:0]       lights,
  output logic [$clog2(N_APPR)-1:0] active,
  output logic [1:0]                phase
);

  localparam int AW = $clog2(N_APPR);
  localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALLRED_T - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [AW-1:0]       r_active;
  logic [AW-1:0]       w_next_active;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_APPR-1:0]   r_pend;
  logic [N_APPR-1:0]   w_pend_next;
  logic [3*N_APPR-1:0] r_lights;
  logic                w_tick;
  logic                w_trans;
  logic                w_side_pend;

  function automatic logic [3*N_APPR-1:0] lamps(input state_t st, input logic [AW-1:0] act);
    logic [3*N_APPR-1:0] v;
    logic [2:0]          code;
    case (st)
      ST_GREEN:  code = LT_GRN;
      ST_YELLOW: code = LT_YEL;
      default:   code = LT_RED;
    endcase
    for (int k = 0; k < N_APPR; k++) begin
      v[3*k +: 3] = (act == AW'(k)) ? code : LT_RED;
    end
    return v;
  endfunction

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_side_pend = |r_pend[N_APPR-1:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_GREEN;
      r_active <= '0;
    end else begin
      r_state  <= w_next_state;
      r_active <= w_next_active;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_active = r_active;
    w_trans       = 1'b0;
    case (r_state)
      ST_GREEN: begin
        if (!w_tick) begin
          w_trans = 1'b0;
        end else if (r_active == '0) begin
          w_trans = (r_cnt >= C_GMIN) && w_side_pend && !preempt;
        end else begin
          w_trans = preempt || (r_cnt == C_GMAX) || ((r_cnt >= C_GMIN) && !sensor[r_active]);
        end
        if (w_trans) begin
          w_next_state = ST_YELLOW;
        end else begin
          w_next_state = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (w_tick && (r_cnt == C_YEL)) begin
          w_trans      = 1'b1;
          w_next_state = ST_ALLRED;
        end else begin
          w_next_state = ST_YELLOW;
        end
      end
      ST_ALLRED: begin
        if (w_tick && (r_cnt == C_AR)) begin
          w_trans      = 1'b1;
          w_next_state = ST_GREEN;
          if (preempt) begin
            w_next_active = '0;
          end else begin
            w_next_active = AW'(next_pending(MAX_APPR'(r_pend), N_APPR, 32'(r_active)));
          end
        end else begin
          w_next_state = ST_ALLRED;
        end
      end
      default: begin
        w_trans       = 1'b1;
        w_next_state  = ST_GREEN;
        w_next_active = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_trans) begin
      r_cnt <= '0;
    end else if (w_tick && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A request raised during its own yellow/all-red survives the clear at its green entry.
  always_comb begin
    w_pend_next    = r_pend | sensor;
    w_pend_next[0] = 1'b0;
    if (w_trans && (w_next_state == ST_GREEN)) begin
      for (int k = 1; k < N_APPR; k++) begin
        if (w_next_active == AW'(k)) begin
          w_pend_next[k] = sensor[k] && (r_active == AW'(k)) && (r_state != ST_GREEN);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= '0;
      r_lights <= lamps(ST_GREEN, '0);
    end else begin
      r_pend   <= w_pend_next;
      r_lights <= lamps(w_next_state, w_next_active);
    end
  end

  assign lights = r_lights;
  assign active = r_active;
  assign phase  = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench: each scenario queues its hand-derived per-cycle phase/approach timeline,
// and a negedge monitor pops and compares against the selected controller instance.
module tb_traffic_phase_controller;

  localparam logic [1:0] PG = 2'd0;
  localparam logic [1:0] PY = 2'd1;
  localparam logic [1:0] PR = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [1:0] sen_a, sen_c;
  logic [2:0] sen_b;
  logic       pre_a, pre_b, pre_c;
  logic [5:0] l_a, l_c;
  logic [8:0] l_b;
  logic       act_a, act_c;
  logic [1:0] act_b;
  logic [1:0] ph_a, ph_b, ph_c;

  traffic_phase_controller #(.N_APPR(2), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(rst_a), .sensor(sen_a), .preempt(pre_a),
    .lights(l_a), .active(act_a), .phase(ph_a)
  );
  traffic_phase_controller #(.N_APPR(3), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .sensor(sen_b), .preempt(pre_b),
    .lights(l_b), .active(act_b), .phase(ph_b)
  );
  traffic_phase_controller #(.N_APPR(2), .TICK_DIV(3)) dut_c (
    .clk(clk), .reset(rst_c), .sensor(sen_c), .preempt(pre_c),
    .lights(l_c), .active(act_c), .phase(ph_c)
  );

  typedef struct {
    logic [1:0] ph;
    int         act;
    int         cyc;
  } exp_t;

  exp_t  q[$];
  int    sel;
  bit    mon_en;
  int    pos;
  string scen;
  int    n_checks;
  int    n_pass;
  int    n_to;

  exp_t       m_e;
  logic [8:0] m_gl, m_el;
  int         m_ga, m_n;
  logic [1:0] m_gp;

  function automatic logic [8:0] exp_lights(int n, logic [1:0] ph, int act);
    logic [8:0] v;
    logic [2:0] c;
    v = 9'd0;
    c = (ph == PG) ? 3'b001 : (ph == PY) ? 3'b010 : 3'b100;
    for (int k = 0; k < n; k++) begin
      v[3*k +: 3] = (k == act) ? c : 3'b100;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en && (q.size() > 0)) begin
      m_e = q.pop_front();
      case (sel)
        0:       begin m_gl = {3'b000, l_a}; m_ga = int'(act_a); m_gp = ph_a; m_n = 2; end
        1:       begin m_gl = l_b;           m_ga = int'(act_b); m_gp = ph_b; m_n = 3; end
        default: begin m_gl = {3'b000, l_c}; m_ga = int'(act_c); m_gp = ph_c; m_n = 2; end
      endcase
      m_el = exp_lights(m_n, m_e.ph, m_e.act);
      n_checks++;
      if ((m_gl === m_el) && (m_ga == m_e.act) && (m_gp === m_e.ph)) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc %0d: got lights=%b active=%0d phase=%0d, want lights=%b active=%0d phase=%0d",
                 scen, m_e.cyc, m_gl, m_ga, m_gp, m_el, m_e.act, m_e.ph);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(logic [1:0] ph, int act, int len);
    for (int i = 0; i < len; i++) begin
      q.push_back('{ph, act, pos});
      pos++;
    end
  endtask

  task automatic start(int s, string nm);
    mon_en = 1'b0;
    sel    = s;
    scen   = nm;
    pos    = 0;
    sen_a  = 2'b00; sen_b = 3'b000; sen_c = 2'b00;
    pre_a  = 1'b0;  pre_b = 1'b0;   pre_c = 1'b0;
    case (s)
      0:       rst_a = 1'b1;
      1:       rst_b = 1'b1;
      default: rst_c = 1'b1;
    endcase
    repeat (3) step();
  endtask

  task automatic release_rst();
    case (sel)
      0:       rst_a = 1'b0;
      1:       rst_b = 1'b0;
      default: rst_c = 1'b0;
    endcase
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q.size() > 0) && (b < 200)) begin
      step();
      b++;
    end
    if (q.size() > 0) begin
      $display("FAIL %s drain: %0d expected entries left, want 0", scen, q.size());
      n_to++;
      q.delete();
    end
    mon_en = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_to = 0; mon_en = 1'b0; sel = 0; pos = 0; scen = "init";
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    sen_a = 2'b00; sen_b = 3'b000; sen_c = 2'b00;
    pre_a = 1'b0; pre_b = 1'b0; pre_c = 1'b0;
    step();

    start(0, "rest");
    seg(PG, 0, 51);
    release_rst();
    drain();

    start(0, "single");
    seg(PG, 0, 4); seg(PY, 0, 2); seg(PR, 0, 1);
    seg(PG, 1, 4); seg(PY, 1, 2); seg(PR, 1, 1);
    seg(PG, 0, 10);
    release_rst();
    step(); sen_a = 2'b10;
    step(); sen_a = 2'b00;
    drain();

    start(0, "extend");
    seg(PG, 0, 4); seg(PY, 0, 2); seg(PR, 0, 1);
    seg(PG, 1, 8); seg(PY, 1, 2); seg(PR, 1, 1);
    seg(PG, 0, 4); seg(PY, 0, 2); seg(PR, 0, 1);
    seg(PG, 1, 3);
    release_rst();
    sen_a = 2'b10;
    drain();
    sen_a = 2'b00;

    start(1, "roundrobin");
    seg(PG, 0, 4); seg(PY, 0, 2); seg(PR, 0, 1);
    seg(PG, 1, 4); seg(PY, 1, 2); seg(PR, 1, 1);
    seg(PG, 2, 4); seg(PY, 2, 2); seg(PR, 2, 1);
    seg(PG, 0, 8);
    release_rst();
    step(); sen_b = 3'b110;
    step(); sen_b = 3'b000;
    drain();

    // Preempt high on cycles 8..16; approach 1 requests on cycle 9 while main is pre-empted.
    start(1, "preempt");
    seg(PG, 0, 4); seg(PY, 0, 2); seg(PR, 0, 1);
    seg(PG, 2, 2); seg(PY, 2, 2); seg(PR, 2, 1);
    seg(PG, 0, 6); seg(PY, 0, 2); seg(PR, 0, 1);
    seg(PG, 1, 4); seg(PY, 1, 2); seg(PR, 1, 1);
    seg(PG, 0, 6);
    release_rst();
    step(); sen_b = 3'b100;
    step(); sen_b = 3'b000;
    repeat (6) step();
    pre_b = 1'b1;
    step(); sen_b = 3'b010;
    step(); sen_b = 3'b000;
    repeat (7) step();
    pre_b = 1'b0;
    drain();

    // Reset lands in yellow; afterwards main must rest until a fresh request on the 3-cycle tick grid.
    start(2, "resetmid");
    seg(PG, 0, 12); seg(PY, 0, 2);
    seg(PG, 0, 33); seg(PY, 0, 6); seg(PR, 0, 3);
    seg(PG, 1, 3);
    release_rst();
    step(); sen_c = 2'b10;
    step(); sen_c = 2'b00;
    repeat (11) step();
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    repeat (30) step();
    sen_c = 2'b10;
    step(); sen_c = 2'b00;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks + n_to);
    $finish;
  end

endmodule
